// File: rtl/rr_sched_pkg.sv
// Shared types for the trace-buffer scheduler: per-channel FSM states and
// bit positions of the sticky error vector.
package rr_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        ACTIVE = 2'd2
    } sched_state_t;

    localparam int ERR_WR_DROP = 0;
    localparam int ERR_RD_DROP = 1;
    localparam int ERR_WR_SPUR = 2;
    localparam int ERR_RD_SPUR = 3;

endpackage

// File: rtl/rr_buf_chan_sched.sv
// One scheduler channel: descriptor FIFO, load/active FSM and completion counter.
//   state  | meaning
//   IDLE   | no buffer owned by rr_trace_rw; pops when enabled and FIFO non-empty
//   LOAD   | buf_update pulse with the latched addr/size
//   ACTIVE | buffer handed over, waiting for its completion interrupt
module rr_buf_chan_sched
    import rr_sched_pkg::*;
#(
    parameter int AW    = 64,
    parameter int DEPTH = 4,
    parameter int CW    = 32
) (
    input  logic          clk,
    input  logic          sync_rst,
    input  logic          enable,
    input  logic          desc_valid,
    output logic          desc_ready,
    input  logic [AW-1:0] desc_addr,
    input  logic [AW-1:0] desc_size,
    output logic [AW-1:0] buf_addr,
    output logic [AW-1:0] buf_size,
    output logic          buf_update,
    input  logic          intr,
    output logic [CW-1:0] done_cnt,
    output logic          starved,
    output logic          err_drop,
    output logic          err_spur
);

    localparam int PW = $clog2(DEPTH);

    logic [AW-1:0] mem_addr [DEPTH];
    logic [AW-1:0] mem_size [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;

    sched_state_t state;
    sched_state_t state_nxt;

    assign empty      = (count == '0);
    assign full       = (count == (PW+1)'(DEPTH));
    assign desc_ready = !full;
    // Zero-length buffers are meaningless to rr_trace_rw, so they never enter the FIFO.
    assign push       = desc_valid && !full && (desc_size != '0);

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (enable && !empty) begin
                    pop       = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: state_nxt = ACTIVE;
            ACTIVE: begin
                if (intr) begin
                    if (enable && !empty) begin
                        pop       = 1'b1;
                        state_nxt = LOAD;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sync_rst) state <= IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr] <= desc_addr;
            mem_size[wr_ptr] <= desc_size;
        end
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            buf_addr <= '0;
            buf_size <= '0;
            done_cnt <= '0;
            err_drop <= 1'b0;
            err_spur <= 1'b0;
        end else begin
            if (pop) begin
                buf_addr <= mem_addr[rd_ptr];
                buf_size <= mem_size[rd_ptr];
            end
            if (state == ACTIVE && intr) done_cnt <= done_cnt + 1'b1;
            // A pop this cycle means the host is about to see space; not a loss.
            if (desc_valid && full && !pop && desc_size != '0) err_drop <= 1'b1;
            if (intr && state != ACTIVE) err_spur <= 1'b1;
        end
    end

    assign buf_update = (state == LOAD);
    assign starved    = (state == IDLE) && empty && (done_cnt != '0);

endmodule

// File: rtl/rr_trace_buf_sched.sv
// Record/replay descriptor scheduler in front of rr_trace_rw: two independent
// channel schedulers plus error-vector assembly.
module rr_trace_buf_sched
    import rr_sched_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int DESC_DEPTH     = 4,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      sync_rst,
    input  logic                      enable,
    input  logic                      wr_desc_valid,
    output logic                      wr_desc_ready,
    input  logic [AXI_ADDR_WIDTH-1:0] wr_desc_addr,
    input  logic [AXI_ADDR_WIDTH-1:0] wr_desc_size,
    input  logic                      rd_desc_valid,
    output logic                      rd_desc_ready,
    input  logic [AXI_ADDR_WIDTH-1:0] rd_desc_addr,
    input  logic [AXI_ADDR_WIDTH-1:0] rd_desc_size,
    output logic [AXI_ADDR_WIDTH-1:0] write_buf_addr,
    output logic [AXI_ADDR_WIDTH-1:0] write_buf_size,
    output logic                      write_buf_update,
    input  logic                      write_interrupt,
    output logic [AXI_ADDR_WIDTH-1:0] read_buf_addr,
    output logic [AXI_ADDR_WIDTH-1:0] read_buf_size,
    output logic                      read_buf_update,
    input  logic                      read_interrupt,
    output logic [CNT_WIDTH-1:0]      wr_done_cnt,
    output logic [CNT_WIDTH-1:0]      rd_done_cnt,
    output logic                      wr_starved,
    output logic                      rd_starved,
    output logic [3:0]                err
);

    logic wr_err_drop, wr_err_spur, rd_err_drop, rd_err_spur;

    rr_buf_chan_sched #(.AW(AXI_ADDR_WIDTH), .DEPTH(DESC_DEPTH), .CW(CNT_WIDTH)) u_wr_chan (
        .clk        (clk),
        .sync_rst   (sync_rst),
        .enable     (enable),
        .desc_valid (wr_desc_valid),
        .desc_ready (wr_desc_ready),
        .desc_addr  (wr_desc_addr),
        .desc_size  (wr_desc_size),
        .buf_addr   (write_buf_addr),
        .buf_size   (write_buf_size),
        .buf_update (write_buf_update),
        .intr       (write_interrupt),
        .done_cnt   (wr_done_cnt),
        .starved    (wr_starved),
        .err_drop   (wr_err_drop),
        .err_spur   (wr_err_spur)
    );

    rr_buf_chan_sched #(.AW(AXI_ADDR_WIDTH), .DEPTH(DESC_DEPTH), .CW(CNT_WIDTH)) u_rd_chan (
        .clk        (clk),
        .sync_rst   (sync_rst),
        .enable     (enable),
        .desc_valid (rd_desc_valid),
        .desc_ready (rd_desc_ready),
        .desc_addr  (rd_desc_addr),
        .desc_size  (rd_desc_size),
        .buf_addr   (read_buf_addr),
        .buf_size   (read_buf_size),
        .buf_update (read_buf_update),
        .intr       (read_interrupt),
        .done_cnt   (rd_done_cnt),
        .starved    (rd_starved),
        .err_drop   (rd_err_drop),
        .err_spur   (rd_err_spur)
    );

    always_comb begin
        err              = '0;
        err[ERR_WR_DROP] = wr_err_drop;
        err[ERR_RD_DROP] = rd_err_drop;
        err[ERR_WR_SPUR] = wr_err_spur;
        err[ERR_RD_SPUR] = rd_err_spur;
    end

endmodule
